// File: rtl/jump_resolve_queue.sv
// jump_resolve_queue: in-order tracker for predicted jumps between fetch and
// execute. Retires the oldest prediction on each resolve, drives the
// history-counter predictor update port and raises mispredict/flush strobes.
module jump_resolve_queue #(
  parameter int ADDR_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int STAT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    enable,
  input  logic                    i_stall,
  input  logic                    i_pred_push,
  input  logic [ADDR_WIDTH-1:0]   i_pred_addr,
  input  logic                    i_pred_jump,
  input  logic                    i_pred_valid,
  output logic                    o_pred_ready,
  output logic                    o_shift_history,
  input  logic                    i_res_valid,
  input  logic [ADDR_WIDTH-1:0]   i_res_addr,
  input  logic                    i_res_jump,
  input  logic                    i_flush,
  output logic                    o_upd_enable,
  output logic [ADDR_WIDTH-1:0]   o_upd_addr,
  output logic                    o_upd_jump,
  output logic                    o_mispredict,
  output logic                    o_flush_history,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [STAT_WIDTH-1:0]   o_mispredict_cnt,
  output logic                    o_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Saturating increment for the mispredict statistic.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
  logic                  entry_pred [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count_next;

  logic active;
  logic push_acc;
  logic pop_acc;
  logic mis;
  logic clear;
  logic err_evt;
  logic head_pred;
  logic [ADDR_WIDTH-1:0] head_addr;

  assign active    = enable & ~i_stall;
  assign head_addr = entry_addr[head];
  assign head_pred = entry_pred[head];

  // Ready looks only at the registered count, so a same-cycle pop never
  // makes room for a push; after reset the empty queue reports ready.
  assign o_pred_ready = (o_count != CNT_W'(DEPTH));

  assign push_acc = active & i_pred_push & o_pred_ready;
  assign pop_acc  = active & i_res_valid & (o_count != '0);
  assign mis      = pop_acc & (i_res_jump != head_pred);
  assign clear    = mis | (active & i_flush);

  // A push that is wiped by a same-cycle mispredict or flush must not
  // shift the speculative history either.
  assign o_shift_history = push_acc & ~clear;

  assign err_evt = (active & i_pred_push & ~o_pred_ready)
                 | (active & i_res_valid & (o_count == '0))
                 | (pop_acc & (i_res_addr != head_addr));

  // Occupancy for the next cycle: net push/pop, or empty on clear.
  always_comb begin
    count_next = o_count;
    if (clear)
      count_next = '0;
    else if (push_acc && !pop_acc)
      count_next = o_count + 1'b1;
    else if (!push_acc && pop_acc)
      count_next = o_count - 1'b1;
  end

  // Entry storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push_acc && !clear) begin
      entry_addr[tail] <= i_pred_addr;
      entry_pred[tail] <= i_pred_jump & i_pred_valid;
    end
  end

  // Pointers, occupancy, registered strobes and statistics.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      head             <= '0;
      tail             <= '0;
      o_count          <= '0;
      o_upd_enable     <= 1'b0;
      o_upd_addr       <= '0;
      o_upd_jump       <= 1'b0;
      o_mispredict     <= 1'b0;
      o_flush_history  <= 1'b0;
      o_mispredict_cnt <= '0;
      o_err            <= 1'b0;
    end else if (active) begin
      o_count <= count_next;
      if (clear) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (pop_acc)  head <= head + 1'b1;
        if (push_acc) tail <= tail + 1'b1;
      end
      o_upd_enable    <= pop_acc;
      o_upd_jump      <= pop_acc & i_res_jump;
      if (pop_acc)
        o_upd_addr    <= i_res_addr;
      o_mispredict    <= mis;
      o_flush_history <= clear;
      if (mis)
        o_mispredict_cnt <= sat_inc(o_mispredict_cnt);
      if (err_evt)
        o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jump_resolve_queue.sv
// Testbench for jump_resolve_queue: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_jump_resolve_queue;

  localparam int AW    = 64;
  localparam int DEPTH = 4;
  localparam int SW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          nreset;
  logic          enable, i_stall;
  logic          i_pred_push, i_pred_jump, i_pred_valid;
  logic [AW-1:0] i_pred_addr;
  logic          o_pred_ready, o_shift_history;
  logic          i_res_valid, i_res_jump, i_flush;
  logic [AW-1:0] i_res_addr;
  logic          o_upd_enable, o_upd_jump, o_mispredict, o_flush_history;
  logic [AW-1:0] o_upd_addr;
  logic [CW-1:0] o_count;
  logic [SW-1:0] o_mispredict_cnt;
  logic          o_err;

  always #5 clk = ~clk;

  jump_resolve_queue #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .STAT_WIDTH(SW)) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .i_stall(i_stall),
    .i_pred_push(i_pred_push), .i_pred_addr(i_pred_addr), .i_pred_jump(i_pred_jump),
    .i_pred_valid(i_pred_valid), .o_pred_ready(o_pred_ready),
    .o_shift_history(o_shift_history), .i_res_valid(i_res_valid),
    .i_res_addr(i_res_addr), .i_res_jump(i_res_jump), .i_flush(i_flush),
    .o_upd_enable(o_upd_enable), .o_upd_addr(o_upd_addr), .o_upd_jump(o_upd_jump),
    .o_mispredict(o_mispredict), .o_flush_history(o_flush_history),
    .o_count(o_count), .o_mispredict_cnt(o_mispredict_cnt), .o_err(o_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state: program-order list of outstanding predictions.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          pred;
  } ent_t;
  ent_t          mq[$];
  logic          m_err, m_upd_en, m_upd_jump, m_mis, m_flh;
  logic [AW-1:0] m_upd_addr;
  logic [SW-1:0] m_mcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_err = 0; m_upd_en = 0; m_upd_jump = 0; m_mis = 0; m_flh = 0;
    m_upd_addr = '0; m_mcnt = '0;
  endtask

  task automatic idle();
    enable = 1; i_stall = 0;
    i_pred_push = 0; i_pred_addr = '0; i_pred_jump = 0; i_pred_valid = 0;
    i_res_valid = 0; i_res_addr = '0; i_res_jump = 0; i_flush = 0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_upd_enable"}, 64'(o_upd_enable), 64'(m_upd_en));
    chk({tag, "_upd_addr"}, o_upd_addr, m_upd_addr);
    chk({tag, "_upd_jump"}, 64'(o_upd_jump), 64'(m_upd_jump));
    chk({tag, "_mispredict"}, 64'(o_mispredict), 64'(m_mis));
    chk({tag, "_flush_history"}, 64'(o_flush_history), 64'(m_flh));
    chk({tag, "_count"}, 64'(o_count), 64'(mq.size()));
    chk({tag, "_err"}, 64'(o_err), 64'(m_err));
    chk({tag, "_mispredict_cnt"}, 64'(o_mispredict_cnt), 64'(m_mcnt));
  endtask

  // One clock: check combinational outputs, advance the model, check the
  // registered outputs just after the edge, return at the next falling edge.
  task automatic tick();
    bit active, ready, push, pop, mis, clr;
    ent_t h;
    #1;
    active = enable && !i_stall;
    ready  = (mq.size() != DEPTH);
    push   = active && i_pred_push && ready;
    pop    = active && i_res_valid && (mq.size() != 0);
    mis    = 0;
    h      = '0;
    if (pop) begin
      h   = mq[0];
      mis = (i_res_jump != h.pred);
    end
    clr = mis || (active && i_flush);
    chk("pred_ready", 64'(o_pred_ready), 64'(ready));
    chk("shift_history", 64'(o_shift_history), 64'(push && !clr));
    if (active) begin
      if (i_pred_push && !ready) m_err = 1;
      if (i_res_valid && mq.size() == 0) m_err = 1;
      if (pop && h.addr != i_res_addr) m_err = 1;
      m_upd_en   = pop;
      m_upd_jump = pop && i_res_jump;
      if (pop) m_upd_addr = i_res_addr;
      m_mis = mis;
      m_flh = clr;
      if (mis && m_mcnt != '1) m_mcnt = m_mcnt + 1;
      if (clr) mq.delete();
      else begin
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({i_pred_addr, i_pred_jump & i_pred_valid});
      end
    end
    @(posedge clk);
    #1;
    check_regs("cyc");
    @(negedge clk);
  endtask

  task automatic drv(input bit push, input logic [AW-1:0] paddr, input bit pjump,
                     input bit pvalid, input bit res, input logic [AW-1:0] raddr,
                     input bit rjump, input bit flush);
    idle();
    i_pred_push = push; i_pred_addr = paddr; i_pred_jump = pjump; i_pred_valid = pvalid;
    i_res_valid = res; i_res_addr = raddr; i_res_jump = rjump; i_flush = flush;
    tick();
  endtask

  initial begin
    // Power-on reset
    idle();
    nreset = 0;
    model_reset();
    #12;
    check_regs("reset");
    @(negedge clk);
    nreset = 1;
    tick();

    // Three pushes, two correct resolves
    drv(1, 'h100, 1, 1, 0, 0, 0, 0);
    drv(1, 'h104, 0, 1, 0, 0, 0, 0);
    drv(1, 'h108, 1, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 'h100, 1, 0);
    chk("t1_upd_a", {o_upd_addr[62:0], o_upd_jump}, {63'h100, 1'b1});
    drv(0, 0, 0, 0, 1, 'h104, 0, 0);
    chk("t1_upd_b", {o_upd_addr[62:0], o_upd_jump}, {63'h104, 1'b0});
    chk("t1_count", 64'(o_count), 1);
    chk("t1_nomis", 64'(o_mispredict), 0);
    drv(0, 0, 0, 0, 1, 'h108, 1, 0);

    // Fill, overflow, drain, push again
    for (int i = 0; i < 4; i++) drv(1, 'h200 + 4 * i, i[0], 1, 0, 0, 0, 0);
    chk("full_ready", 64'(o_pred_ready), 0);
    drv(1, 'h2F0, 1, 1, 0, 0, 0, 0);
    chk("full_err", 64'(o_err), 1);
    chk("full_count", 64'(o_count), 4);
    for (int i = 0; i < 4; i++) drv(0, 0, 0, 0, 1, 'h200 + 4 * i, i[0], 0);
    drv(1, 'h300, 0, 1, 0, 0, 0, 0);
    chk("refill_count", 64'(o_count), 1);
    drv(0, 0, 0, 0, 1, 'h300, 0, 0);

    // Invalid predictor entry counts as not-taken
    drv(1, 'h400, 1, 0, 0, 0, 0, 0);
    drv(1, 'h404, 1, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 'h400, 1, 0);
    chk("inv_mis", 64'(o_mispredict), 1);
    chk("inv_flh", 64'(o_flush_history), 1);
    chk("inv_count", 64'(o_count), 0);
    chk("inv_mcnt", 64'(o_mispredict_cnt), 1);

    // Mispredict with same-cycle push
    drv(1, 'h500, 0, 1, 0, 0, 0, 0);
    drv(1, 'h504, 1, 1, 1, 'h500, 1, 0);
    chk("mispush_count", 64'(o_count), 0);

    // Stall holds everything
    drv(1, 'h600, 1, 1, 0, 0, 0, 0);
    drv(1, 'h604, 0, 1, 1, 'h600, 1, 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      i_stall = 1;
      i_pred_push = i[0]; i_pred_addr = 'h700; i_res_valid = !i[0];
      i_res_addr = 'h604; i_res_jump = 1; i_flush = (i == 2);
      tick();
      chk("stall_upd_hold", 64'(o_upd_enable), 1);
      chk("stall_count_hold", 64'(o_count), 1);
    end
    drv(0, 0, 0, 0, 1, 'h604, 0, 0);

    // Resolve on empty, wrong address, flush alone, flush with resolve
    drv(0, 0, 0, 0, 1, 'h800, 1, 0);
    chk("empty_noupd", 64'(o_upd_enable), 0);
    drv(1, 'h900, 1, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 'h9FC, 1, 0);
    chk("badaddr_upd", o_upd_addr, 'h9FC);
    drv(0, 0, 0, 0, 0, 0, 0, 1);
    chk("flush_alone", {62'b0, o_flush_history, o_upd_enable}, 2'b10);
    drv(1, 'hA00, 0, 1, 0, 0, 0, 0);
    drv(1, 'hA04, 0, 1, 1, 'hA00, 0, 1);
    chk("flush_res", {61'b0, o_upd_enable, o_mispredict, o_flush_history}, 3'b101);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      idle();
      enable       = ($urandom_range(0, 19) != 0);
      i_stall      = ($urandom_range(0, 14) == 0);
      i_pred_push  = 1'($urandom_range(0, 1));
      i_pred_addr  = {$urandom, $urandom};
      i_pred_jump  = 1'($urandom_range(0, 1));
      i_pred_valid = ($urandom_range(0, 3) != 0);
      i_res_valid  = ($urandom_range(0, 2) == 0);
      i_flush      = ($urandom_range(0, 39) == 0);
      if (mq.size() != 0) begin
        i_res_addr = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : mq[0].addr;
        i_res_jump = ($urandom_range(0, 7) == 0) ? !mq[0].pred : mq[0].pred;
      end else begin
        i_res_addr = {$urandom, $urandom};
        i_res_jump = 1'($urandom_range(0, 1));
      end
      tick();
    end

    // Asynchronous reset between clock edges
    drv(1, 'hB00, 1, 1, 0, 0, 0, 0);
    drv(1, 'hB04, 1, 1, 1, 'hB00, 0, 0);
    idle();
    #2;
    nreset = 0;
    #1;
    model_reset();
    check_regs("async_reset");
    @(negedge clk);
    nreset = 1;
    tick();
    drv(1, 'hC00, 1, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 1, 'hC00, 1, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
